// File: rtl/pjon_rx_frame_check.sv
`default_nettype none
// ==========================================================================
// pjon_rx_frame_check : PJON frame checker, buffers and forwards payload.
// Revision 1.0
// ==========================================================================
module pjon_rx_frame_check #(
  parameter int MaxPayload = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dev_id_i,
  input  logic [7:0] s_tdata_i,
  input  logic       s_tvalid_i,
  input  logic       s_tlast_i,
  output logic       s_tready_o,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  output logic       m_tlast_o,
  input  logic       m_tready_i,
  output logic       pkt_ok_o,
  output logic       ack_req_o,
  output logic       pkt_err_o,
  output logic [2:0] err_code_o
);

  localparam int         AW     = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam logic [8:0] MaxLen = 9'(MaxPayload + 5);

  localparam logic [2:0] ErrHcrc  = 3'd1;
  localparam logic [2:0] ErrFcrc  = 3'd2;
  localparam logic [2:0] ErrLen   = 3'd3;
  localparam logic [2:0] ErrUnsup = 3'd4;
  localparam logic [2:0] ErrAddr  = 3'd5;
  localparam logic [2:0] ErrTrunc = 3'd6;
  localparam logic [2:0] ErrOver  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_HCRC, ST_PAYLOAD, ST_FCRC, ST_FWD, ST_DROP
  } state_e;

  state_e     state_q;
  logic [7:0] crc_q, id_q, len_q, cnt_q, rd_q;
  logic       ack_bit_q;
  logic [7:0] buf_q [2**AW];
  logic [7:0] m_tdata_q;
  logic       m_tvalid_q, m_tlast_q;
  logic       pkt_ok_q, ack_q, pkt_err_q;
  logic [2:0] err_code_q;

  logic       byte_fire, fwd_hs;
  logic [2:0] byte_err;
  logic [7:0] crc_upd, pay_len, cnt_nx, rd_nx;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 8'h97) : (r >> 1);
    end
    return r;
  endfunction

  assign s_tready_o = ~rst_i & (state_q != ST_FWD);
  assign byte_fire  = s_tvalid_i & s_tready_o;
  assign fwd_hs     = m_tvalid_q & m_tready_i;
  assign crc_upd    = crc8_upd((state_q == ST_IDLE) ? 8'h00 : crc_q, s_tdata_i);
  assign pay_len    = len_q - 8'd5;
  assign cnt_nx     = cnt_q + 8'd1;
  assign rd_nx      = rd_q + 8'd1;

  assign m_tdata_o  = m_tdata_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tlast_o  = m_tlast_q;
  assign pkt_ok_o   = pkt_ok_q;
  assign ack_req_o  = ack_q;
  assign pkt_err_o  = pkt_err_q;
  assign err_code_o = err_code_q;

  // Content errors of the current byte outrank truncation on that same byte.
  always_comb begin
    byte_err = 3'd0;
    case (state_q)
      ST_IDLE: if (s_tlast_i) byte_err = ErrTrunc;
      ST_HDR: begin
        if ((s_tdata_i & 8'hFB) != 8'h00) byte_err = ErrUnsup;
        else if (s_tlast_i)               byte_err = ErrTrunc;
      end
      ST_LEN: begin
        if (s_tdata_i < 8'd5 || {1'b0, s_tdata_i} > MaxLen) byte_err = ErrLen;
        else if (s_tlast_i)                                  byte_err = ErrTrunc;
      end
      ST_HCRC: begin
        if (s_tdata_i != crc_q)                            byte_err = ErrHcrc;
        else if (id_q != dev_id_i && id_q != 8'h00)        byte_err = ErrAddr;
        else if (s_tlast_i)                                byte_err = ErrTrunc;
      end
      ST_PAYLOAD: if (s_tlast_i) byte_err = ErrTrunc;
      ST_FCRC: begin
        if (s_tdata_i != crc_q) byte_err = ErrFcrc;
        else if (!s_tlast_i)    byte_err = ErrOver;
      end
      default: byte_err = 3'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (byte_fire && state_q == ST_PAYLOAD) begin
      buf_q[cnt_q[AW-1:0]] <= s_tdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      crc_q      <= 8'h00;
      id_q       <= 8'h00;
      len_q      <= 8'h00;
      cnt_q      <= 8'h00;
      rd_q       <= 8'h00;
      ack_bit_q  <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      pkt_ok_q   <= 1'b0;
      ack_q      <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      pkt_ok_q  <= 1'b0;
      ack_q     <= 1'b0;
      pkt_err_q <= 1'b0;
      case (state_q)
        ST_FWD: begin
          if (fwd_hs) begin
            if (m_tlast_q) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              m_tdata_q  <= 8'h00;
              state_q    <= ST_IDLE;
            end else begin
              rd_q      <= rd_nx;
              m_tdata_q <= buf_q[rd_nx[AW-1:0]];
              m_tlast_q <= ((rd_nx + 8'd1) == pay_len);
            end
          end
        end
        ST_DROP: begin
          if (byte_fire && s_tlast_i) state_q <= ST_IDLE;
        end
        default: begin
          if (byte_fire) begin
            if (byte_err != 3'd0) begin
              pkt_err_q  <= 1'b1;
              err_code_q <= byte_err;
              state_q    <= s_tlast_i ? ST_IDLE : ST_DROP;
            end else begin
              crc_q <= crc_upd;
              case (state_q)
                ST_IDLE: begin
                  id_q    <= s_tdata_i;
                  state_q <= ST_HDR;
                end
                ST_HDR: begin
                  ack_bit_q <= s_tdata_i[2];
                  state_q   <= ST_LEN;
                end
                ST_LEN: begin
                  len_q   <= s_tdata_i;
                  state_q <= ST_HCRC;
                end
                ST_HCRC: begin
                  cnt_q   <= 8'h00;
                  state_q <= (len_q == 8'd5) ? ST_FCRC : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                  cnt_q <= cnt_nx;
                  if (cnt_nx == pay_len) state_q <= ST_FCRC;
                end
                ST_FCRC: begin
                  pkt_ok_q <= 1'b1;
                  ack_q    <= ack_bit_q & (id_q != 8'h00);
                  if (len_q != 8'd5) begin
                    rd_q       <= 8'h00;
                    m_tvalid_q <= 1'b1;
                    m_tdata_q  <= buf_q[0];
                    m_tlast_q  <= (pay_len == 8'd1);
                    state_q    <= ST_FWD;
                  end else begin
                    state_q <= ST_IDLE;
                  end
                end
                default: state_q <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pjon_rx_frame_check.sv
`default_nettype none
// tb_pjon_rx_frame_check : directed frames checked against a byte-index frame model.
module tb_pjon_rx_frame_check;

  localparam int MAXP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dev = 8'h2A;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0;
  logic       s_tready_o;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o, m_tlast_o;
  logic       m_tready = 1'b1;
  logic       pkt_ok_o, ack_req_o, pkt_err_o;
  logic [2:0] err_code_o;

  pjon_rx_frame_check #(.MaxPayload(MAXP)) dut (
    .clk_i(clk), .rst_i(rst), .dev_id_i(dev),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready),
    .pkt_ok_o(pkt_ok_o), .ack_req_o(ack_req_o), .pkt_err_o(pkt_err_o), .err_code_o(err_code_o)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, exp_cyc = -1;
  logic rst_d1 = 1'b1;
  bit chk_en = 0, stall_mode = 0;
  bit exp_ok, exp_ack;
  logic [2:0] exp_code;
  logic [7:0] exp_q[$];
  logic [7:0] pq[$];
  logic [7:0] fr [0:31];
  int fn;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= rst;
  end

  initial forever begin
    @(posedge clk); #1;
    m_tready = stall_mode ? ~m_tready : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 8'h97) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] crc_of(input int n);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < n; k++) c = crc8(c, fr[k]);
    return c;
  endfunction

  // Walks the frame by byte position and returns where and how it is decided.
  task automatic model(output int d, output bit ok, output logic [2:0] code, output bit ack);
    int L = 0;
    d = fn - 1; ok = 0; code = 3'd0; ack = 0;
    pq.delete();
    for (int i = 0; i < fn; i++) begin
      bit last = (i == fn - 1);
      logic [2:0] e = 3'd0;
      if (i == 1 && (fr[1] & 8'hFB) != 8'h00) e = 3'd4;
      else if (i == 2) begin
        L = int'(fr[2]);
        if (L < 5 || L > MAXP + 5) e = 3'd3;
      end else if (i == 3) begin
        if (crc_of(3) != fr[3]) e = 3'd1;
        else if (fr[0] != dev && fr[0] != 8'h00) e = 3'd5;
      end else if (i >= 4 && i == L - 1) begin
        if (crc_of(i) != fr[i]) e = 3'd2;
        else if (!last) e = 3'd7;
        else begin
          d = i; ok = 1; ack = fr[1][2] && (fr[0] != 8'h00);
          for (int k = 4; k < i; k++) pq.push_back(fr[k]);
          return;
        end
      end
      if (e == 3'd0 && last) e = 3'd6;
      if (e != 3'd0) begin d = i; code = e; return; end
    end
  endtask

  task automatic build(input logic [7:0] id, input logic [7:0] hdr, input int np, input logic [31:0] pay);
    fr[0] = id; fr[1] = hdr; fr[2] = 8'(np + 5);
    fr[3] = crc_of(3);
    for (int k = 0; k < np; k++) fr[4 + k] = pay[8*k +: 8];
    fr[np + 4] = crc_of(np + 4);
    fn = np + 5;
  endtask

  // Called at posedge+1; returns at posedge+1 of the consuming edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit r;
    int g = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    forever begin
      @(negedge clk); r = s_tready_o;
      @(posedge clk);
      g++;
      if (r) break;
      if (g > 60) begin
        chk("s_tready_timeout", 32'(r), 32'd1);
        break;
      end
    end
    #1;
  endtask

  task automatic send_frame();
    int d; bit ok, ack; logic [2:0] code;
    model(d, ok, code, ack);
    for (int i = 0; i < fn; i++) begin
      send_byte(fr[i], i == fn - 1);
      if (i == d) begin
        exp_ok = ok; exp_ack = ack; exp_code = code;
        if (ok) foreach (pq[k]) exp_q.push_back(pq[k]);
        exp_cyc = cyc;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int g = 0; g < 200 && exp_q.size() != 0; g++) begin @(posedge clk); #1; end
    chk("beats_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) chk("s_tready_in_reset", 32'(s_tready_o), 0);
      if (rst && rst_d1)
        chk("outputs_in_reset", {m_tvalid_o, m_tlast_o, m_tdata_o, pkt_ok_o, ack_req_o, pkt_err_o, err_code_o}, 0);
      if (cyc == exp_cyc) begin
        chk("pkt_ok", 32'(pkt_ok_o), 32'(exp_ok));
        chk("ack_req", 32'(ack_req_o), 32'(exp_ack));
        chk("pkt_err", 32'(pkt_err_o), 32'(!exp_ok));
        if (!exp_ok) chk("err_code", 32'(err_code_o), 32'(exp_code));
        if (exp_ok) chk("tvalid_with_ok", 32'(m_tvalid_o), 32'(exp_q.size() != 0));
      end else if (pkt_ok_o || pkt_err_o || ack_req_o) begin
        chk("stray_pulse", {pkt_ok_o, pkt_err_o, ack_req_o}, 0);
      end
      if (m_tvalid_o) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {m_tdata_o, m_tlast_o}, 0);
        else begin
          chk("m_tdata", 32'(m_tdata_o), 32'(exp_q[0]));
          chk("m_tlast", 32'(m_tlast_o), 32'(exp_q.size() == 1));
          if (m_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int d; bit ok, ack; logic [2:0] code;
    @(posedge clk); #1; chk_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk); chk("s_tready_after_reset", 32'(s_tready_o), 1);
    @(posedge clk); #1;

    // Hand-computed pins for the CRC and the model.
    fr[0] = 8'h01; chk("pin_crc_01", 32'(crc_of(1)), 32'h86);
    build(8'h2A, 8'h00, 3, 32'h00332211);
    chk("pin_hcrc_2a0008", 32'(fr[3]), 32'h8B);
    model(d, ok, code, ack);
    chk("pin_model_ok", {ok, ack, 8'(d)}, {1'b1, 1'b0, 8'd7});
    chk("pin_model_payload", {pq[0], pq[1], pq[2]}, 24'h112233);

    send_frame();                                    // basic good frame
    build(8'h2A, 8'h04, 3, 32'h00332211);
    stall_mode = 1; send_frame(); stall_mode = 0;    // ACK request with output stalls
    build(8'h2A, 8'h00, 3, 32'h00332211);
    fr[7] = fr[7] ^ 8'h01; send_frame();             // bad frame CRC
    build(8'h2A, 8'h00, 3, 32'h00332211); send_frame();
    build(8'h10, 8'h00, 4, 32'h44332211);            // foreign recipient, L=9
    model(d, ok, code, ack);
    chk("pin_model_addr", {ok, 8'(d), 5'(code)}, {1'b0, 8'd3, 5'd5});
    send_frame();
    fr[0] = 8'h2A; fr[1] = 8'h00; fr[2] = 8'h03;     // short length, drained to tlast
    fr[3] = 8'h55; fr[4] = 8'h66; fr[5] = 8'h77; fr[6] = 8'h88; fn = 7;
    send_frame();
    build(8'h2A, 8'h00, 3, 32'h00332211); fn = 6; send_frame();  // truncated in payload
    build(8'h2A, 8'h00, 4, 32'hDDCCBBAA); send_frame();
    build(8'h00, 8'h04, 2, 32'h0000BEEF); send_frame();          // broadcast, never ACKed
    build(8'h2A, 8'h04, 0, 32'h0); send_frame();                 // L=5, no beats
    build(8'h2A, 8'h01, 2, 32'h00005A5A); send_frame();          // unsupported header
    build(8'h2A, 8'h00, 2, 32'h00005A5A); fr[3] = fr[3] ^ 8'hFF; send_frame();
    build(8'h2A, 8'h00, 3, 32'h00010203); fr[8] = 8'hEE; fn = 9; send_frame(); // overlength
    build(8'h2A, 8'h00, 1, 32'h000000C3); send_frame();

    // Reset in the middle of a payload.
    build(8'h2A, 8'h00, 3, 32'h00332211);
    for (int i = 0; i < 6; i++) send_byte(fr[i], 1'b0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk); chk("s_tready_after_mid_reset", 32'(s_tready_o), 1);
    @(posedge clk); #1;
    build(8'h2A, 8'h04, 2, 32'h00009876); send_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
